// File: rtl/ttl_pkg.sv
// rtl/ttl_pkg.sv - shared constants and helpers for 74-series TTL equivalents
package ttl_pkg;
  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] NIBBLE_MAX = 4'hF;

  function automatic int counter_width(int stages);
    return stages * NIBBLE_W;
  endfunction
endpackage

// File: rtl/ls74161.sv
// rtl/ls74161.sv - one 74LS161-equivalent 4-bit synchronous counter stage
module ls74161
  import ttl_pkg::*;
(
  input  logic                clk,
  input  logic                clr_n,
  input  logic                load_n,
  input  logic                enp,
  input  logic                ent,
  input  logic [NIBBLE_W-1:0] d,
  output logic [NIBBLE_W-1:0] q,
  output logic                rco
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (!load_n) begin
      q <= d;
    end else if (enp && ent) begin
      q <= q + 1'b1;
    end
  end

  // Carry ignores enp so a paused cascade still reports terminal count.
  assign rco = ent && (q == NIBBLE_MAX);

endmodule

// File: rtl/ls74161_pc_counter.sv
// rtl/ls74161_pc_counter.sv - program counter built from cascaded ls74161 stages
module ls74161_pc_counter
  import ttl_pkg::*;
#(
  parameter int STAGES = 2,
  localparam int W = counter_width(STAGES)
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load_n,
  input  logic         enp,
  input  logic         ent,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rco
);

  // carry[i] is the ent of stage i; every stage clocks on the same edge.
  logic [STAGES:0] carry;

  assign carry[0] = ent;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    ls74161 u_stage (
      .clk    (clk),
      .clr_n  (clr_n),
      .load_n (load_n),
      .enp    (enp),
      .ent    (carry[i]),
      .d      (d[i*NIBBLE_W +: NIBBLE_W]),
      .q      (q[i*NIBBLE_W +: NIBBLE_W]),
      .rco    (carry[i+1])
    );
  end

  assign rco = carry[STAGES];

endmodule

// File: tb/tb_ls74161_pc_counter.sv
// tb/tb_ls74161_pc_counter.sv - scoreboard bench for the cascaded program counter
module tb_ls74161_pc_counter;

  logic       clk = 1'b0;
  logic       clr_n, load_n, enp, ent;
  logic [7:0] d, q;
  logic       rco;

  always #5 clk = ~clk;

  ls74161_pc_counter #(.STAGES(2)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .load_n (load_n),
    .enp    (enp),
    .ent    (ent),
    .d      (d),
    .q      (q),
    .rco    (rco)
  );

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       rco;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  event       chk_now;
  logic [7:0] mq;

  // Monitor: compares the oldest expectation at each falling edge or on demand.
  exp_t e;
  initial begin
    forever begin
      @(negedge clk or chk_now);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q !== e.q || rco !== e.rco) begin
          errors++;
          $display("FAIL %s: got q=%h rco=%b, expected q=%h rco=%b", e.name, q, rco, e.q, e.rco);
        end
      end
    end
  end

  function automatic logic [7:0] mux157(logic [7:0] a, logic [7:0] b, logic sel, logic en_n);
    return en_n ? 8'h00 : (sel ? b : a);
  endfunction

  task automatic expect_now(string n);
    exp_t x;
    x.name = n;
    x.q    = mq;
    x.rco  = ent && (mq == 8'hFF);
    sb.push_back(x);
  endtask

  // One clocked operation: drive, let the edge happen, predict, wait for the check.
  task automatic step(string n, logic ln, logic p, logic t, logic [7:0] dv);
    load_n = ln;
    enp    = p;
    ent    = t;
    d      = dv;
    @(posedge clk);
    if (!ln)
      mq = dv;
    else if (p && t)
      mq = mq + 8'd1;
    expect_now(n);
    @(negedge clk);
    #1;
  endtask

  task automatic comb_check(string n, logic t);
    ent = t;
    #1;
    expect_now(n);
    -> chk_now;
    #1;
  endtask

  task automatic clear_pulse(string n, int edges);
    clr_n = 1'b0;
    mq    = 8'h00;
    #1;
    expect_now(n);
    -> chk_now;
    #1;
    if (edges > 0) begin
      load_n = 1'b0;
      enp    = 1'b1;
      ent    = 1'b1;
      d      = 8'h77;
      repeat (edges) @(posedge clk);
      #1;
      expect_now({n, "_hold"});
      -> chk_now;
      #1;
      @(negedge clk);
      #1;
    end
    clr_n  = 1'b1;
    load_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    clr_n  = 1'b0;
    load_n = 1'b1;
    enp    = 1'b0;
    ent    = 1'b0;
    d      = 8'h00;
    mq     = 8'h00;
    expect_now("reset");
    @(negedge clk);
    #1;
    clr_n = 1'b1;

    step("load_5a", 1'b0, 1'b0, 1'b0, 8'h5A);
    clear_pulse("async_clr", 0);

    step("load_a5",  1'b0, 1'b1, 1'b1, 8'hA5);
    step("count_a6", 1'b1, 1'b1, 1'b1, 8'h00);

    step("load_0f",  1'b0, 1'b0, 1'b0, 8'h0F);
    step("carry_10", 1'b1, 1'b1, 1'b1, 8'h00);
    step("load_1e",  1'b0, 1'b0, 1'b0, 8'h1E);
    step("count_1f", 1'b1, 1'b1, 1'b1, 8'h00);
    step("count_20", 1'b1, 1'b1, 1'b1, 8'h00);

    step("load_ff",      1'b0, 1'b0, 1'b1, 8'hFF);
    comb_check("ent0_ff", 1'b0);
    step("hold_ff_ent0", 1'b1, 1'b1, 1'b0, 8'h00);
    comb_check("ent1_ff", 1'b1);
    step("wrap_00",      1'b1, 1'b1, 1'b1, 8'h00);

    step("load_3c",   1'b0, 1'b0, 1'b0, 8'h3C);
    step("enp0_hold", 1'b1, 1'b0, 1'b1, 8'h00);
    step("ent0_hold", 1'b1, 1'b1, 1'b0, 8'h00);
    step("load_ff2",  1'b0, 1'b0, 1'b0, 8'hFF);
    step("enp0_ff",   1'b1, 1'b0, 1'b1, 8'h00);

    clear_pulse("clr_over_load", 1);

    step("mux_sel_b", 1'b0, 1'b0, 1'b0, mux157(8'h0A, 8'h15, 1'b1, 1'b0));
    step("mux_dis",   1'b0, 1'b0, 1'b0, mux157(8'h0A, 8'h15, 1'b1, 1'b1));

    for (int i = 0; i < 250; i++) begin
      int sel;
      logic [7:0] dv;
      sel = int'($urandom_range(0, 19));
      dv  = ($urandom_range(0, 3) == 0) ? 8'hFE + 8'($urandom_range(0, 1)) : 8'($urandom);
      if (sel == 0)
        clear_pulse("rnd_clr", int'($urandom_range(0, 1)));
      else if (sel == 1)
        comb_check("rnd_comb", 1'($urandom_range(0, 1)));
      else
        step("rnd", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0, dv);
    end

    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls74161_pc_counter.md
Name: ls74161_pc_counter

Overview:
- Cascadable synchronous binary counter built from 74LS161-equivalent 4-bit stages; serves as the CPU program counter.
- Sits directly downstream of the ls74157 quad 2:1 mux. The mux output y (selected between PC+1 path and branch target) drives this block's parallel-load data.
- Reproduces 74LS161 behaviour exactly: async clear, synchronous load, dual count enables, ripple carry out.

Parameters:
- STAGES, 2, number of cascaded 4-bit stages; counter width is 4*STAGES (default 8 bits).

Ports:
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low clear
- load_n  input  1  synchronous active-low parallel load
- enp  input  1  count enable P, common to all stages
- ent  input  1  count enable T, drives stage 0 only
- d  input  4*STAGES  parallel load data, fed from ls74157 y outputs
- q  output  4*STAGES  counter value
- rco  output  1  ripple carry out of the last stage

Behaviour:
- Clock and reset (already decided): one clock, clk; reset clr_n is asynchronous and active-low.
- Reset:
  - clr_n=0 forces q to 0 immediately, independent of clk.
  - While clr_n is low, loads and counts are ignored.
  - rco is 0 during reset, because q=0.
  - Clear mid-count or mid-load aborts the operation; no partial update survives.
- Priority at a rising clk edge with clr_n=1:
  1. load_n=0: q <= d, regardless of enp/ent.
  2. Otherwise, if enp=1 and the stage's ent=1: that stage increments mod 16.
  3. Otherwise: hold.
- Cascade:
  - Stage 0 ent = port ent.
  - Stage i ent = rco of stage i-1.
  - All stages share enp, load_n, clk, clr_n.
  - Cascading is fully synchronous: all stages update on the same edge, with no ripple clocking.
- Per-stage rco = ent_stage AND (stage q == 4'hF). It is combinational and does not depend on enp.
- Port rco = rco of stage STAGES-1. It equals ent AND (q == all ones).
- Latency:
  - Load and count take effect one clk edge after the inputs are sampled.
  - rco follows q and ent combinationally, with zero-cycle latency.
- Wrap-around: at all ones with enp=ent=1, the next edge gives q=0. rco is 1 during the all-ones cycle and 0 after.
- Simultaneous events:
  - Load and count together: load wins.
  - Clear and load together: clear wins.
  - Load of all ones with ent=1: rco is asserted in the following cycle.
- enp=0, ent=1: q holds, and rco still reflects all-ones detection (74LS161 behaviour).
- Upper bits of d are used on load even when only the low stages would count.
- No X-propagation tolerance is required: all inputs must be driven.
- Any upstream mux disable (enable_n=1 gives y=0) is loaded as 0 if load_n=0.

Decomposition:
- Shared package ttl_pkg:
  - NIBBLE_W = 4
  - NIBBLE_MAX = 4'hF
  - a function giving counter width from STAGES
- Sub-module ls74161:
  - Single 4-bit stage with ports clk, clr_n, load_n, enp, ent, d[3:0], q[3:0], rco.
  - Instantiated STAGES times by a generate loop.
  - The sub-module is reusable elsewhere in the CPU (e.g. microcode step counter).

Test Plan:
- Async clear: with STAGES=2, load 8'h5A, then pulse clr_n low between clock edges -> q=8'h00 immediately, without waiting for an edge; rco=0.
- Sync load: d=8'hA5, load_n=0, enp=ent=1 -> q=8'hA5 after one edge and no increment on that edge; with load_n released, the next edge gives 8'hA6.
- Cascade carry: load 8'h0F, count one edge -> q=8'h10 (stage 1 increments only because stage 0 rco=1). From 8'h1E, two edges give 8'h1F then 8'h20.
- Wrap and rco: load 8'hFF with ent=1 -> rco=1 with no clock edge needed. One count edge gives q=8'h00 and rco=0. With ent=0 at 8'hFF, rco=0 and q holds.
- Enable matrix at q=8'h3C:
  - enp=0, ent=1: holds 8'h3C.
  - enp=1, ent=0: holds 8'h3C.
  - enp=0, ent=1 at q=8'hFF: rco=1 and q holds.
- Mux integration: drive d from an ls74157 with a=4'hA/4'h0 per nibble and b=4'h5/4'h1, select=1, enable_n=0, load_n=0 -> q=8'h15. Repeat with enable_n=1 -> q=8'h00.
